// File: rtl/maxnet_if.sv
// Handshake and result bundle between the MAXNET scheduler and its environment.
// The slave modport is the scheduler side; master is the sequencer/bank side.
interface maxnet_if #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2
);
    logic                 start;
    logic [N_NEURONS-1:0] nz_flags;
    logic                 plu_done;
    logic                 load_we;
    logic                 plu_start;
    logic                 act_we;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     winner;
    logic                 no_winner;
    logic                 timeout;
    logic [7:0]           iter_cnt;

    modport master (
        output start, nz_flags, plu_done,
        input  load_we, plu_start, act_we, busy, done,
        input  winner, no_winner, timeout, iter_cnt
    );

    modport slave (
        input  start, nz_flags, plu_done,
        output load_we, plu_start, act_we, busy, done,
        output winner, no_winner, timeout, iter_cnt
    );
endinterface

// File: rtl/maxnet_sched.sv
// MAXNET winner-take-all scheduler: load, then PLU pass / write-back until at most one neuron survives.
// Latency: start to done is 3 cycles plus (plu latency + 3) per pass; enables are Moore outputs of the state.
// Backpressure: WAIT stalls indefinitely on plu_done; MAXNET_TIMEOUT_EN adds an iteration limit of MAX_ITER.
module maxnet_sched #(
    parameter int N_NEURONS = 4,
    parameter int MAX_ITER  = 15,
    parameter int IDX_W     = 2
) (
    input  logic     clk,
    input  logic     rst,
    maxnet_if.slave  bus
);
    localparam int PW = $clog2(N_NEURONS + 1);
`ifdef MAXNET_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, WAIT, WB, FIN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pop;
    logic [IDX_W-1:0] low_idx;
    logic             limit;
    logic             finish;
    logic [IDX_W-1:0] winner_q;
    logic             no_winner_q;
    logic             timeout_q;
    logic [7:0]       iter_q;

    // Scanning from the top leaves the lowest set index, which is also the sole index when pop==1.
    always_comb begin
        pop     = '0;
        low_idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (bus.nz_flags[i]) begin
                pop     = pop + PW'(1);
                low_idx = IDX_W'(i);
            end
        end
    end

    assign limit  = TMO_EN && (iter_q == 8'(MAX_ITER));
    assign finish = (pop <= PW'(1)) || limit;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.load_we   = 1'b0;
        bus.plu_start = 1'b0;
        bus.act_we    = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);
        case (state_q)
            IDLE:  if (bus.start) state_d = LOAD;
            LOAD:  begin bus.load_we = 1'b1; state_d = CHECK; end
            CHECK: state_d = finish ? FIN : RUN;
            RUN:   begin bus.plu_start = 1'b1; state_d = WAIT; end
            WAIT:  if (bus.plu_done) state_d = WB;
            WB:    begin bus.act_we = 1'b1; state_d = CHECK; end
            FIN:   begin bus.done = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner_q    <= '0;
            no_winner_q <= 1'b0;
            timeout_q   <= 1'b0;
            iter_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    winner_q    <= '0;
                    no_winner_q <= 1'b0;
                    timeout_q   <= 1'b0;
                    iter_q      <= '0;
                end
                CHECK: if (finish) begin
                    winner_q    <= low_idx;
                    no_winner_q <= (pop == PW'(0));
                    timeout_q   <= (pop > PW'(1));
                end
                WB: if (iter_q != 8'hFF) iter_q <= iter_q + 8'd1;
                default: ;
            endcase
        end
    end

    assign bus.winner    = winner_q;
    assign bus.no_winner = no_winner_q;
    assign bus.timeout   = TMO_EN ? timeout_q : 1'b0;
    assign bus.iter_cnt  = iter_q;
endmodule

// File: tb/tb_maxnet_sched.sv
// Bench for maxnet_sched: directed scenarios plus random flag sequences checked against a pass-level model.
module tb_maxnet_sched;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int MI = 2;
`ifdef MAXNET_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    maxnet_if #(.N_NEURONS(N), .IDX_W(IW)) bus();
    maxnet_sched #(.N_NEURONS(N), .MAX_ITER(MI), .IDX_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] plan[$];

    bit          r_done;
    int          r_lat, r_load, r_start, r_we, r_bad;
    logic [IW-1:0] r_win;
    logic        r_nowin, r_tmo;
    logic [7:0]  r_iter;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] f);
        for (int i = 0; i < N; i++) if (f[i]) return i;
        return 0;
    endfunction

    // Acts as bank + PLU: plan[k] is the flag vector seen after k write-backs.
    task automatic run(input int dly, input int budget, input bit hold);
        int pass = 0;
        int pd = 0;
        r_done = 0; r_lat = 0; r_load = 0; r_start = 0; r_we = 0; r_bad = 0;
        bus.nz_flags = plan[0];
        bus.start = 1'b1;
        while (!r_done && r_lat < budget) begin
            @(negedge clk);
            r_lat++;
            if (!hold) bus.start = 1'b0;
            bus.plu_done = 1'b0;
            if (pd > 0) begin
                pd--;
                if (pd == 0) bus.plu_done = 1'b1;
            end
            if (bus.load_we) r_load++;
            if (bus.plu_start) begin r_start++; pd = dly; end
            if (bus.act_we) begin
                r_we++;
                pass++;
                bus.nz_flags = plan[pass < plan.size() ? pass : plan.size() - 1];
            end
            if (int'(bus.load_we) + int'(bus.plu_start) + int'(bus.act_we) > 1 || !bus.busy) r_bad++;
            if (bus.done) begin
                r_done  = 1;
                r_win   = bus.winner;
                r_nowin = bus.no_winner;
                r_tmo   = bus.timeout;
                r_iter  = bus.iter_cnt;
            end
        end
        bus.plu_done = 1'b0;
        if (!hold) begin
            bus.start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_check(input string tag, input int dly);
        int passes = 0;
        int win = 0;
        int pc;
        bit nowin = 0;
        bit tmo = 0;
        logic [N-1:0] f;
        for (int k = 0; k < 256; k++) begin
            f  = plan[k < plan.size() ? k : plan.size() - 1];
            pc = $countones(f);
            if (pc <= 1 || (TMO_EN && k == MI)) begin
                passes = k; nowin = (pc == 0); tmo = (pc >= 2); win = lowest(f);
                break;
            end
        end
        run(dly, 3 + passes * (dly + 3) + 5, 1'b0);
        check($sformatf("%s.done", tag), r_done, 1);
        check($sformatf("%s.latency", tag), r_lat, 3 + passes * (dly + 3));
        check($sformatf("%s.load_we", tag), r_load, 1);
        check($sformatf("%s.plu_start", tag), r_start, passes);
        check($sformatf("%s.act_we", tag), r_we, passes);
        check($sformatf("%s.protocol", tag), r_bad, 0);
        check($sformatf("%s.winner", tag), r_win, win);
        check($sformatf("%s.no_winner", tag), r_nowin, nowin);
        check($sformatf("%s.timeout", tag), r_tmo, tmo);
        check($sformatf("%s.iter_cnt", tag), r_iter, passes);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, guard, len;
        bit got;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.nz_flags = '0;
        bus.plu_done = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", bus.busy, 0);
        check("reset.outputs", {bus.load_we, bus.plu_start, bus.act_we, bus.done,
              bus.winner, bus.no_winner, bus.timeout, bus.iter_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        plan = '{4'b0100};
        run_check("single", 2);
        plan = '{4'b1011, 4'b1011, 4'b1011, 4'b0010};
        run_check("three_pass", 5);
        plan = '{4'b1100, 4'b0000};
        run_check("tie", 3);

        plan = '{4'b0011};
`ifdef MAXNET_TIMEOUT_EN
        run_check("limit", 2);
`else
        run(2, 2 + 20 * 5, 1'b0);
        check("nolimit.done", r_done, 0);
        check("nolimit.plu_start", r_start, 20);
        check("nolimit.act_we", r_we, 20);
        check("nolimit.iter_cnt", bus.iter_cnt, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        // Reset while stalled in WAIT on the second pass; plu_done held high elsewhere must be ignored.
        bus.nz_flags = 4'b1011;
        bus.start = 1'b1;
        bus.plu_done = 1'b1;
        seen = 0;
        guard = 0;
        while (seen < 2 && guard < 50) begin
            @(negedge clk);
            bus.start = 1'b0;
            guard++;
            if (bus.plu_start) seen++;
        end
        bus.plu_done = 1'b0;
        @(negedge clk);
        check("wait.reached", seen, 2);
        check("wait.iter_cnt", bus.iter_cnt, 1);
        check("wait.busy", bus.busy, 1);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check("midrst.busy", bus.busy, 0);
        check("midrst.outputs", {bus.load_we, bus.plu_start, bus.act_we, bus.done,
              bus.winner, bus.no_winner, bus.timeout, bus.iter_cnt}, 0);
        @(negedge clk);
        check("midrst.start_ignored", bus.busy, 0);
        bus.plu_done = 1'b1;
        @(negedge clk);
        bus.plu_done = 1'b0;
        @(negedge clk);
        check("stray_done.busy", bus.busy, 0);
        plan = '{4'b1011, 4'b0001};
        run_check("after_rst", 1);

        // Start held through a run: the second run begins only after FIN returns to IDLE.
        plan = '{4'b1000};
        run(1, 10, 1'b1);
        check("hold.done", r_done, 1);
        check("hold.winner", r_win, 3);
        @(negedge clk);
        check("hold.idle_gap", bus.busy, 0);
        check("hold.winner_kept", bus.winner, 3);
        @(negedge clk);
        check("hold.second_load", bus.load_we, 1);
        bus.start = 1'b0;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1;
        end
        check("hold.second_done", got, 1);
        @(negedge clk);
        repeat (3) begin
            bus.plu_done = 1'b1;
            @(negedge clk);
        end
        bus.plu_done = 1'b0;
        check("idle_plu_done.busy", bus.busy, 0);
        check("idle_plu_done.winner", bus.winner, 3);
        check("idle_plu_done.iter_cnt", bus.iter_cnt, 0);

        for (int r = 0; r < 8; r++) begin
            plan.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < len - 1; i++) plan.push_back(N'($urandom));
            begin
                int v = $urandom_range(0, N);
                plan.push_back(v == 0 ? '0 : N'(1 << (v - 1)));
            end
            run_check($sformatf("rand%0d", r), $urandom_range(1, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
